// File: rtl/sm_hex_display_pkg.sv
// Shared types and constants for the 8-digit hex display scanner.
package sm_hex_display_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam int unsigned DIGITS     = 8;
    localparam logic [6:0]  SEG_OFF    = 7'h7F;
    localparam logic [7:0]  ANODES_OFF = 8'hFF;

endpackage

// File: rtl/sm_hex_display.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module sm_hex_display (
    input  logic [3:0] hex,
    output logic [6:0] segments
);

    always_comb begin
        segments = 7'h7F;
        case (hex)
            4'h0: segments = 7'b1000000;
            4'h1: segments = 7'b1111001;
            4'h2: segments = 7'b0100100;
            4'h3: segments = 7'b0110000;
            4'h4: segments = 7'b0011001;
            4'h5: segments = 7'b0010010;
            4'h6: segments = 7'b0000010;
            4'h7: segments = 7'b1111000;
            4'h8: segments = 7'b0000000;
            4'h9: segments = 7'b0010000;
            4'hA: segments = 7'b0001000;
            4'hB: segments = 7'b0000011;
            4'hC: segments = 7'b1000110;
            4'hD: segments = 7'b0100001;
            4'hE: segments = 7'b0000110;
            4'hF: segments = 7'b0001110;
            default: segments = 7'h7F;
        endcase
    end

endmodule

// File: rtl/sm_hex_display_scan_ctrl.sv
// Multiplexed 8-digit hex display scanner with a one-deep number buffer.
// Optional leading-zero blanking: define SM_HEX_DISPLAY_LZ_BLANK_EN.
module sm_hex_display_scan_ctrl
    import sm_hex_display_pkg::*;
#(
    parameter int unsigned DIV = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] number,
    input  logic        num_valid,
    output logic        num_ready,
    input  logic [7:0]  digit_mask,
    output logic [6:0]  seven_segments,
    output logic        dot,
    output logic [7:0]  anodes,
    output logic        frame_done
);

    localparam logic [15:0] PRESC_LAST = 16'(DIV - 1);
    localparam logic [2:0]  IDX_LAST   = 3'(DIGITS - 1);

    scan_state_t state, state_nx;
    logic [15:0] presc;
    logic [2:0]  idx;
    logic [31:0] active;
    logic [31:0] pending;
    logic        pend_full;
    logic        tick;
    logic        boundary;
    logic        xfer;
    logic [3:0]  nibble;
    logic [6:0]  seg_dec;
    logic [7:0]  digit_blank;
    logic [6:0]  seg_nx;
    logic [7:0]  an_nx;

    assign tick      = (state == DRIVE) && (presc == PRESC_LAST);
    assign boundary  = tick && (idx == IDX_LAST);
    assign num_ready = ~pend_full;
    assign xfer      = num_valid && !pend_full;
    assign nibble    = active[{idx, 2'b00} +: 4];

    sm_hex_display u_dec (
        .hex      (nibble),
        .segments (seg_dec)
    );

`ifdef SM_HEX_DISPLAY_LZ_BLANK_EN
    // Digit k is a leading zero when every nibble from k upward is zero.
    always_comb begin
        digit_blank = '0;
        for (int unsigned k = 1; k < DIGITS; k++) begin
            digit_blank[k] = ((active >> (4 * k)) == 32'd0);
        end
    end
`else
    assign digit_blank = '0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            BLANK:   state_nx = DRIVE;
            DRIVE:   if (tick) state_nx = BLANK;
            default: state_nx = BLANK;
        endcase
    end

    always_comb begin
        seg_nx = SEG_OFF;
        an_nx  = ANODES_OFF;
        if (state == DRIVE) begin
            seg_nx = seg_dec;
            if (digit_mask[idx] && !digit_blank[idx]) begin
                an_nx = ~(8'b1 << idx);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= BLANK;
            presc          <= '0;
            idx            <= '0;
            active         <= '0;
            pending        <= '0;
            pend_full      <= 1'b0;
            seven_segments <= SEG_OFF;
            anodes         <= ANODES_OFF;
            dot            <= 1'b1;
            frame_done     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == DRIVE) begin
                presc <= tick ? '0 : presc + 16'd1;
            end
            if (tick) begin
                idx <= idx + 3'd1;
            end
            // Active only changes on the frame boundary; an empty buffer
            // lets a coincident transfer bypass straight into active.
            if (boundary) begin
                if (pend_full) begin
                    active    <= pending;
                    pend_full <= 1'b0;
                end else if (xfer) begin
                    active <= number;
                end
            end else if (xfer) begin
                pending   <= number;
                pend_full <= 1'b1;
            end
            seven_segments <= seg_nx;
            anodes         <= an_nx;
            dot            <= 1'b1;
            frame_done     <= boundary;
        end
    end

endmodule

// File: tb/tb_sm_hex_display_scan_ctrl.sv
// Self-checking bench for sm_hex_display_scan_ctrl (DIV=4), cycle-level reference model.
module tb_sm_hex_display_scan_ctrl;

    localparam int unsigned DIV   = 4;
    localparam int unsigned SLOT  = DIV + 1;
    localparam int unsigned FRAME = 8 * SLOT;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] number = '0;
    logic        num_valid = 1'b0;
    logic        num_ready;
    logic [7:0]  digit_mask = 8'hFF;
    logic [6:0]  seven_segments;
    logic        dot;
    logic [7:0]  anodes;
    logic        frame_done;

    sm_hex_display_scan_ctrl #(.DIV(DIV)) dut (
        .clock          (clock),
        .reset          (reset),
        .number         (number),
        .num_valid      (num_valid),
        .num_ready      (num_ready),
        .digit_mask     (digit_mask),
        .seven_segments (seven_segments),
        .dot            (dot),
        .anodes         (anodes),
        .frame_done     (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } hex_vec_t;

    hex_vec_t vecs[16];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: cycles since reset release, buffer contents.
    int unsigned cyc = 0;
    logic [31:0] m_active = '0;
    logic [31:0] m_pend = '0;
    bit          m_full = 1'b0;
    int unsigned tcount = 0;
    int unsigned fd_last = 0;
    bit          fd_have = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic fail_timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    task automatic step();
        int unsigned c, d, p;
        bit          bnd, xf, rst, blanked;
        logic [31:0] act_b;
        logic [7:0]  msk;
        logic [6:0]  e_seg;
        logic [7:0]  e_an;
        bit          e_fd;
        c     = cyc;
        bnd   = (c % FRAME) == FRAME - 1;
        xf    = num_valid && !m_full;
        rst   = reset;
        act_b = m_active;
        msk   = digit_mask;
        @(posedge clock);
        #1;
        tcount++;
        e_seg = 7'h7F;
        e_an  = 8'hFF;
        e_fd  = 1'b0;
        if (rst) begin
            cyc      = 0;
            m_active = '0;
            m_full   = 1'b0;
            fd_have  = 1'b0;
        end else begin
            p = c % SLOT;
            d = (c / SLOT) % 8;
            e_fd = bnd;
            if (p != 0) begin
                e_seg = vecs[act_b[4*d +: 4]].seg;
                blanked = 1'b0;
`ifdef SM_HEX_DISPLAY_LZ_BLANK_EN
                blanked = (d >= 1) && ((act_b >> (4 * d)) == 32'd0);
`endif
                if (msk[d] && !blanked) e_an = ~(8'b1 << d);
            end
            if (bnd) begin
                if (m_full) begin
                    m_active = m_pend;
                    m_full   = 1'b0;
                end else if (xf) begin
                    m_active = number;
                end
            end else if (xf) begin
                m_pend = number;
                m_full = 1'b1;
            end
            cyc++;
        end
        chk("seven_segments", {25'd0, seven_segments}, {25'd0, e_seg});
        chk("anodes", {24'd0, anodes}, {24'd0, e_an});
        chk("dot", {31'd0, dot}, 32'd1);
        chk("num_ready", {31'd0, num_ready}, {31'd0, !m_full});
        chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
        if (!rst && frame_done === 1'b1) begin
            if (fd_have) chk("frame_period", tcount - fd_last, FRAME);
            fd_last = tcount;
            fd_have = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        num_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic send(input logic [31:0] val, input string name);
        int i;
        for (i = 0; i < 200 && num_ready !== 1'b1; i++) step();
        if (num_ready !== 1'b1) fail_timeout(name);
        number    = val;
        num_valid = 1'b1;
        step();
        num_valid = 1'b0;
    endtask

    task automatic wait_fd(input string name);
        int i;
        step();
        for (i = 0; i < 2 * FRAME && frame_done !== 1'b1; i++) step();
        if (frame_done !== 1'b1) fail_timeout(name);
    endtask

    task automatic wait_anodes(input logic [7:0] want, input string name);
        int i;
        for (i = 0; i < 2 * FRAME && anodes !== want; i++) step();
        if (anodes !== want) fail_timeout(name);
    endtask

    initial begin
        vecs[0]  = '{4'h0, 7'b1000000};
        vecs[1]  = '{4'h1, 7'b1111001};
        vecs[2]  = '{4'h2, 7'b0100100};
        vecs[3]  = '{4'h3, 7'b0110000};
        vecs[4]  = '{4'h4, 7'b0011001};
        vecs[5]  = '{4'h5, 7'b0010010};
        vecs[6]  = '{4'h6, 7'b0000010};
        vecs[7]  = '{4'h7, 7'b1111000};
        vecs[8]  = '{4'h8, 7'b0000000};
        vecs[9]  = '{4'h9, 7'b0010000};
        vecs[10] = '{4'hA, 7'b0001000};
        vecs[11] = '{4'hB, 7'b0000011};
        vecs[12] = '{4'hC, 7'b1000110};
        vecs[13] = '{4'hD, 7'b0100001};
        vecs[14] = '{4'hE, 7'b0000110};
        vecs[15] = '{4'hF, 7'b0001110};

        // Reset state, then first number reaches digit 0 after a frame boundary.
        do_reset();
        chk("reset_anodes", {24'd0, anodes}, 32'hFF);
        chk("reset_ready", {31'd0, num_ready}, 32'd1);
        send(32'h12345678, "send_first");
        chk("ready_after_xfer", {31'd0, num_ready}, 32'd0);
        wait_fd("first_boundary");
        chk("ready_after_boundary", {31'd0, num_ready}, 32'd1);
        wait_anodes(8'hFE, "digit0_first");
        for (int k = 0; k < int'(DIV); k++) begin
            chk("digit0_seg8", {25'd0, seven_segments}, {25'd0, 7'b0000000});
            chk("digit0_anode", {24'd0, anodes}, 32'hFE);
            step();
        end
        chk("gap_after_digit0", {24'd0, anodes}, 32'hFF);

        // Decode table: every nibble value on all digits.
        for (int i = 0; i < 16; i++) begin
            send({8{vecs[i].nib}}, "send_table");
            wait_fd("table_boundary");
            wait_anodes(8'hFE, "table_digit0");
            chk("table_seg", {25'd0, seven_segments}, {25'd0, vecs[i].seg});
        end

        // Second number mid-frame is held; valid ignored while full.
        do_reset();
        send(32'hAAAAAAAA, "send_A");
        wait_fd("A_boundary");
        repeat (7) step();
        send(32'h55555555, "send_5");
        chk("ready_low_when_full", {31'd0, num_ready}, 32'd0);
        number    = 32'h12345678;
        num_valid = 1'b1;
        repeat (20) step();
        num_valid = 1'b0;
        repeat (2 * FRAME) step();

        // Transfer exactly at the boundary with buffer empty bypasses to active.
        for (int i = 0; i < 2 * int'(FRAME) && !(((cyc % FRAME) == FRAME - 1) && !m_full); i++) step();
        number    = 32'h9ABCDEF0;
        num_valid = 1'b1;
        step();
        num_valid = 1'b0;
        chk("direct_load_ready", {31'd0, num_ready}, 32'd1);
        repeat (FRAME) step();

        // Fully masked frame: anodes stay off, frame_done keeps its period.
        digit_mask = 8'h00;
        repeat (3 * FRAME) step();
        digit_mask = 8'hFF;

`ifdef SM_HEX_DISPLAY_LZ_BLANK_EN
        send(32'h00000F00, "send_lz");
        wait_fd("lz_boundary");
        repeat (2 * FRAME) step();
`endif

        // Reset during digit 5's slot restarts the scan at digit 0.
        send(32'h87654321, "send_before_rst");
        for (int i = 0; i < 2 * int'(FRAME) && !(((cyc / SLOT) % 8 == 5) && (cyc % SLOT == 2)); i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midslot_rst_anodes", {24'd0, anodes}, 32'hFF);
        chk("midslot_rst_ready", {31'd0, num_ready}, 32'd1);
        wait_anodes(8'hFE, "restart_digit0");
        chk("restart_seg0", {25'd0, seven_segments}, {25'd0, vecs[0].seg});

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            number     = $urandom;
            num_valid  = ($urandom_range(0, 3) == 0);
            digit_mask = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            reset      = ($urandom_range(0, 299) == 0);
            step();
        end
        reset     = 1'b0;
        num_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sm_hex_display_scan_ctrl.md
SM_HEX_DISPLAY_SCAN_CTRL -- requirements
Module: sm_hex_display_scan_ctrl

Interface
REQ-001 Parameter DIV, default 1000, SHALL set clock cycles per digit drive slot (legal range 2..65535).
REQ-002 clock  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-004 number  in  32  8 hex nibbles to display; nibble k (bits 4k+3..4k) is digit k, digit 0 rightmost.
REQ-005 num_valid  in  1  SHALL qualify number for a valid/ready handshake.
REQ-006 num_ready  out  1  SHALL be high when the pending buffer is empty.
REQ-007 digit_mask  in  8  bit k=1 SHALL enable digit k; sampled every cycle.
REQ-008 seven_segments  out  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 dot  out  1  active-low decimal point, registered.
REQ-010 anodes  out  8  active-low digit select, registered; at most one bit low.
REQ-011 frame_done  out  1  SHALL pulse for one cycle when digit 7's slot ends.

Function
REQ-012 Prescaler SHALL count 0..DIV-1 in DRIVE and assert tick at DIV-1, then wrap to 0.
REQ-013 FSM states SHALL be BLANK and DRIVE; BLANK->DRIVE after exactly 1 cycle; DRIVE->BLANK on tick.
REQ-014 On DRIVE->BLANK, digit index SHALL increment modulo 8 (7 wraps to 0).
REQ-015 In BLANK, anodes SHALL be 8'hFF and seven_segments 7'h7F on the following cycle (anti-ghosting).
REQ-016 In DRIVE with index i, the next cycle SHALL show seven_segments = hex-decode(active[4i+3:4i]) and anodes = ~(1<<i), unless digit i is masked or blanked, in which case anodes = 8'hFF.
REQ-017 Output latency SHALL be exactly 1 cycle from state/index to pins.
REQ-018 dot SHALL be 1 (off) at all times.
REQ-019 A transfer SHALL occur when num_valid && num_ready; number is captured into pending and num_ready drops next cycle.
REQ-020 Frame boundary (tick with index 7) SHALL copy pending to active, free pending, and raise num_ready next cycle.
REQ-021 A transfer coinciding with a frame boundary while pending is empty SHALL load active directly and leave pending empty.
REQ-022 With pending full, num_valid SHALL be ignored and active SHALL change only at frame boundaries (no tearing mid-frame).
REQ-023 frame_done SHALL be asserted the cycle after the index-7 tick.

Reset
REQ-024 Reset SHALL force: state BLANK, index 0, prescaler 0, active 0, pending empty, seven_segments 7'h7F, dot 1, anodes 8'hFF, num_ready 1, frame_done 0.
REQ-025 Reset asserted mid-slot or mid-handshake SHALL discard pending and active contents with no partial output.

Configuration
REQ-026 Macro SM_HEX_DISPLAY_LZ_BLANK_EN defined: digit i (i>=1) SHALL be blanked when active nibbles i..7 are all zero; digit 0 never blanked.
REQ-027 Macro undefined: no leading-zero blanking; all enabled digits SHALL show their nibble, including zeros.

Structure
REQ-028 Package sm_hex_display_pkg SHALL hold the state enum, DIGITS=8, SEG_OFF=7'h7F, and ANODES_OFF=8'hFF.
REQ-029 Hex-to-segment decoding SHALL be one instance of sub-module sm_hex_display, driven by the selected nibble.

Verification
REQ-030 DIV=4, reset released, number=32'h12345678 accepted: digit 0 first drives anodes=8'hFE, seg=7'b0000000 ('8') for 4 cycles, after active is loaded at the first frame boundary.
REQ-031 Between every pair of digit slots, exactly 1 cycle SHALL show anodes=8'hFF.
REQ-032 Send 32'hAAAAAAAA, then 32'h55555555 mid-frame: num_ready=0 after the second transfer, and no frame mixes A and 5.
REQ-033 With LZ_BLANK_EN and number=32'h00000F00: digits 3..7 show anodes=8'hFF, digit 2 seg=7'b0001110, digits 1 and 0 show '0'.
REQ-034 digit_mask=8'h00: anodes=8'hFF for a full frame, and frame_done still pulses every 8*(DIV+1) cycles.
REQ-035 Assert reset for 1 cycle during digit 5's slot: the next cycle shows anodes=8'hFF and num_ready=1, and the scan restarts at digit 0.
